// File: rtl/z80bm_pkg.sv
// Shared types and constants for the Z80 bus master: FSM states, cycle types, wait counter width.
package z80bm_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } state_t;

  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_WR = 2'b01,
    IO_RD  = 2'b10,
    IO_WR  = 2'b11
  } cyc_t;

  function automatic cyc_t make_cyc(input logic io, input logic rnw);
    return cyc_t'({io, ~rnw});
  endfunction

  function automatic logic cyc_is_io(input cyc_t c);
    return (c == IO_RD) || (c == IO_WR);
  endfunction

  function automatic logic cyc_is_rd(input cyc_t c);
    return (c == MEM_RD) || (c == IO_RD);
  endfunction

  // Wait-state parameters wider than the counter clamp to its maximum.
  function automatic logic [WAIT_W-1:0] sat_waits(input int unsigned n);
    if ((n >> WAIT_W) != 0) return '1;
    return n[WAIT_W-1:0];
  endfunction

endpackage

// File: rtl/z80bm_wait_cnt.sv
// Auto-wait-state down counter: loadable, decrements while enabled, saturates at zero.
module z80bm_wait_cnt
  import z80bm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus cycle generator (memory/I-O, read/write) with automatic and external wait states.
// Define Z80BM_WAIT_EN to let wait_n extend cycles; otherwise only the auto-waits apply.
module z80_bus_master
  import z80bm_pkg::*;
#(
  parameter int unsigned MEM_WAITS = 0,
  parameter int unsigned IO_WAITS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_io,
  input  logic        cmd_rnw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] a,
  output logic [7:0]  d_o,
  output logic        d_oe,
  input  logic [7:0]  d_i,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        wait_n
);

  state_t            state, state_nxt;
  cyc_t              cyc, cyc_nxt;
  logic              accept;
  logic              wait_ok;
  logic              cnt_zero;
  logic [WAIT_W-1:0] auto_waits;
  logic              in_cyc, in_late, nxt_io, nxt_rd;
  logic              mreq_nxt, iorq_nxt, rd_nxt, wr_nxt, oe_nxt;

`ifdef Z80BM_WAIT_EN
  assign wait_ok = wait_n;
`else
  logic unused_wait_n;
  assign unused_wait_n = wait_n;
  assign wait_ok       = 1'b1;
`endif

  assign accept     = cmd_valid && cmd_ready;
  assign auto_waits = cyc_is_io(cyc) ? sat_waits(IO_WAITS) : sat_waits(MEM_WAITS);

  // Loaded in T1 so T2 sees the full count; T2 and each TW consume one.
  z80bm_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == T1),
    .dec      ((state == T2) || (state == TW)),
    .load_val (auto_waits),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = T1;
          cyc_nxt   = make_cyc(cmd_io, cmd_rnw);
        end
      end
      T1:      state_nxt = T2;
      T2:      state_nxt = (!cnt_zero || !wait_ok) ? TW : T3;
      TW:      state_nxt = (cnt_zero && wait_ok) ? T3 : TW;
      T3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are computed from the next state so the registered outputs line up with the state.
  always_comb begin
    in_cyc   = state_nxt inside {T1, T2, TW, T3};
    in_late  = state_nxt inside {T2, TW, T3};
    nxt_io   = cyc_is_io(cyc_nxt);
    nxt_rd   = cyc_is_rd(cyc_nxt);
    mreq_nxt = in_cyc && !nxt_io;
    iorq_nxt = in_late && nxt_io;
    rd_nxt   = nxt_rd && (nxt_io ? in_late : in_cyc);
    wr_nxt   = !nxt_rd && in_late;
    oe_nxt   = !nxt_rd && in_cyc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc   <= MEM_RD;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      a         <= '0;
      d_o       <= '0;
      d_oe      <= 1'b0;
      mreq_n    <= 1'b1;
      iorq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state == T3);
      mreq_n    <= ~mreq_nxt;
      iorq_n    <= ~iorq_nxt;
      rd_n      <= ~rd_nxt;
      wr_n      <= ~wr_nxt;
      d_oe      <= oe_nxt;
      if (accept) begin
        a <= cmd_addr;
        if (!cmd_rnw) d_o <= cmd_wdata;
      end
      if ((state == T3) && cyc_is_rd(cyc)) rsp_rdata <= d_i;
    end
  end

  a_req_excl: assert property (@(posedge clk) disable iff (!rst_n) !(!mreq_n && !iorq_n));
  a_dir_excl: assert property (@(posedge clk) disable iff (!rst_n) !(!rd_n && !wr_n));

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed and randomised checks of z80_bus_master with MEM_WAITS=0, IO_WAITS=1.
module tb_z80_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_io = 1'b0, cmd_rnw = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] a;
  logic [7:0]  d_o;
  logic        d_oe;
  logic [7:0]  d_i = '0;
  logic        mreq_n, iorq_n, rd_n, wr_n;
  logic        wait_n = 1'b1;

`ifdef Z80BM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  z80_bus_master #(.MEM_WAITS(0), .IO_WAITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_io(cmd_io), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .a(a), .d_o(d_o), .d_oe(d_oe), .d_i(d_i),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n)
  );

  int unsigned n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observations of the last command
  int unsigned o_mreq, o_iorq, o_rd, o_wr, o_oe, o_lat, o_ovl, o_busy_rdy;
  logic [15:0] o_a;
  logic [7:0]  o_do, o_rdata;

  task automatic wait_ready(input string tag);
    int unsigned guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_cmd(input logic io, input logic rnw, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] din, input int unsigned wlow);
    o_mreq = 0; o_iorq = 0; o_rd = 0; o_wr = 0; o_oe = 0;
    o_lat = 0; o_ovl = 0; o_busy_rdy = 0; o_a = '0; o_do = '0; o_rdata = '0;
    wait_ready("ready_wait");
    cmd_valid = 1'b1; cmd_io = io; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd;
    d_i = din; wait_n = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int unsigned cyc = 1; cyc <= 40; cyc++) begin
      wait_n = !((cyc >= 2) && ((cyc - 2) < wlow));
      if (cyc == 1) o_a = a;
      if (!mreq_n) o_mreq++;
      if (!iorq_n) o_iorq++;
      if (!rd_n)   o_rd++;
      if (!wr_n)   o_wr++;
      if (d_oe) begin o_oe++; o_do = d_o; end
      if ((!mreq_n && !iorq_n) || (!rd_n && !wr_n)) o_ovl++;
      if (rsp_valid) begin
        o_lat = cyc;
        o_rdata = rsp_rdata;
        break;
      end
      if (cmd_ready) o_busy_rdy++;
      tick();
    end
    wait_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t1_first, t1_second, nrsp, ovl_tot, exp_lat, w, aw;
    logic prev_mreq;
    logic [15:0] a_second;
    logic r_io, r_rnw;
    logic [7:0] r_wd, r_din;

    // Reset values
    tick(); tick();
    chk("rst_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n}), 32'hF);
    chk("rst_d_oe", 32'(d_oe), 32'd0);
    chk("rst_d_o", 32'(d_o), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    chk("ready_before_clk", 32'(cmd_ready), 32'd0);
    tick();
    chk("ready_first_clk", 32'(cmd_ready), 32'd1);

    // Memory write 0x1234 <- 0x5A
    do_cmd(1'b0, 1'b0, 16'h1234, 8'h5A, 8'hEE, 0);
    chk("mw_a", 32'(o_a), 32'h1234);
    chk("mw_mreq", o_mreq, 32'd3);
    chk("mw_wr", o_wr, 32'd2);
    chk("mw_rd_iorq", o_rd + o_iorq, 32'd0);
    chk("mw_oe", o_oe, 32'd3);
    chk("mw_do", 32'(o_do), 32'h5A);
    chk("mw_lat", o_lat, 32'd4);
    chk("mw_rdata_hold", 32'(o_rdata), 32'h00);
    chk("mw_busy_ready", o_busy_rdy, 32'd0);
    chk("mw_ovl", o_ovl, 32'd0);

    // I/O read 0x83AB -> 0xC3 with one auto wait
    do_cmd(1'b1, 1'b1, 16'h83AB, 8'h00, 8'hC3, 0);
    chk("ir_a", 32'(o_a), 32'h83AB);
    chk("ir_iorq", o_iorq, 32'd3);
    chk("ir_rd", o_rd, 32'd3);
    chk("ir_mreq_wr_oe", o_mreq + o_wr + o_oe, 32'd0);
    chk("ir_lat", o_lat, 32'd5);
    chk("ir_rdata", 32'(o_rdata), 32'hC3);

    // Memory write must leave rsp_rdata untouched
    do_cmd(1'b0, 1'b0, 16'h0001, 8'h99, 8'h11, 0);
    chk("mw2_rdata_hold", 32'(o_rdata), 32'hC3);

    // Memory read with wait_n low for 3 clks from T2
    do_cmd(1'b0, 1'b1, 16'hBEEF, 8'h00, 8'h96, 3);
    chk("mrw_lat", o_lat, WAIT_EN ? 32'd7 : 32'd4);
    chk("mrw_mreq", o_mreq, WAIT_EN ? 32'd6 : 32'd3);
    chk("mrw_rd", o_rd, WAIT_EN ? 32'd6 : 32'd3);
    chk("mrw_rdata", 32'(o_rdata), 32'h96);

    // I/O write
    do_cmd(1'b1, 1'b0, 16'h0042, 8'hA5, 8'h00, 0);
    chk("iw_iorq", o_iorq, 32'd3);
    chk("iw_wr", o_wr, 32'd3);
    chk("iw_oe", o_oe, 32'd4);
    chk("iw_do", 32'(o_do), 32'hA5);
    chk("iw_lat", o_lat, 32'd5);
    chk("iw_rdata_hold", 32'(o_rdata), 32'h96);

    // Back-to-back commands with cmd_valid held high
    wait_ready("b2b_ready");
    cmd_valid = 1'b1; cmd_io = 1'b0; cmd_rnw = 1'b0; cmd_addr = 16'h1111; cmd_wdata = 8'h11;
    t1_first = 0; t1_second = 0; nrsp = 0; ovl_tot = 0; prev_mreq = 1'b1; a_second = '0;
    for (int unsigned cyc = 1; cyc <= 14; cyc++) begin
      tick();
      if (cyc == 1) begin cmd_addr = 16'h2222; cmd_wdata = 8'h22; end
      if (prev_mreq && !mreq_n) begin
        if (t1_first == 0) t1_first = cyc;
        else if (t1_second == 0) begin
          t1_second = cyc;
          a_second = a;
          cmd_valid = 1'b0;
        end
      end
      if (cyc == 12) cmd_valid = 1'b0;
      prev_mreq = mreq_n;
      if (rsp_valid) nrsp++;
      if ((!mreq_n && !iorq_n) || (!rd_n && !wr_n)) ovl_tot++;
    end
    chk("b2b_t1_first", t1_first, 32'd1);
    chk("b2b_spacing", t1_second - t1_first, 32'd4);
    chk("b2b_a_second", 32'(a_second), 32'h2222);
    chk("b2b_nrsp", nrsp, 32'd2);
    chk("b2b_ovl", ovl_tot, 32'd0);

    // Reset asserted during TW of an I/O write
    wait_ready("abort_ready");
    cmd_valid = 1'b1; cmd_io = 1'b1; cmd_rnw = 1'b0; cmd_addr = 16'h00F0; cmd_wdata = 8'h77;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("abort_tw_iorq", 32'({iorq_n, wr_n, d_oe}), 32'b001);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n}), 32'hF);
    chk("abort_d_oe", 32'(d_oe), 32'd0);
    nrsp = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (rsp_valid) nrsp++;
      tick();
    end
    rst_n = 1'b1;
    chk("abort_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("abort_ready_rise", 32'(cmd_ready), 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      if (rsp_valid) nrsp++;
      tick();
    end
    chk("abort_no_rsp", nrsp, 32'd0);

    // Random commands: latency model and strobe exclusivity
    ovl_tot = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      r_io  = 1'($urandom_range(0, 1));
      r_rnw = 1'($urandom_range(0, 1));
      r_wd  = 8'($urandom);
      r_din = 8'($urandom);
      w     = $urandom_range(0, 2);
      do_cmd(r_io, r_rnw, 16'($urandom), r_wd, r_din, w);
      aw = r_io ? 1 : 0;
      if (!WAIT_EN) w = 0;
      exp_lat = 4 + ((aw > w) ? aw : w);
      chk("rnd_lat", o_lat, exp_lat);
      if (r_rnw) chk("rnd_rdata", 32'(o_rdata), 32'(r_din));
      ovl_tot += o_ovl;
    end
    chk("rnd_ovl", ovl_tot, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
